// File: rtl/saes_pkg.sv
// Shared constants and helpers for the small-AES shift/mix datapath.
package saes_pkg;

    // Bit position of the low bit of each state nibble inside a 16-bit beat.
    localparam int S00_LSB = 12;
    localparam int S10_LSB = 8;
    localparam int S01_LSB = 4;
    localparam int S11_LSB = 0;

    // x^4 reduces to x+1 under the field polynomial x^4+x+1.
    localparam logic [3:0] GF_MOD   = 4'h3;
    // Column mixing multiplies the partner nibble by this constant.
    localparam logic [3:0] MIX_COEF = 4'h4;

    // Occupancy of the output register plus skid register.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } bufState_e;

    // Multiply by x in GF(2^4), folding the carried-out x^4 term back in.
    function automatic logic [3:0] xtime(input logic [3:0] a);
        return a[3] ? ({a[2:0], 1'b0} ^ GF_MOD) : {a[2:0], 1'b0};
    endfunction

    // General GF(2^4) product built from repeated xtime steps.
    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] pow;
        acc = 4'h0;
        pow = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ pow;
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16_mul4.sv
// Combinational multiply of one nibble by the mix coefficient.
module gf16_mul4
    import saes_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    assign y_o = gfMul(x_i, MIX_COEF);

endmodule

// File: rtl/shift_mix_stage.sv
// ShiftRows + MixColumns stage with a valid/ready output buffer.
// The transform is purely combinational in front of the registers; the
// buffer is either a single output register or output plus one skid entry.
module shift_mix_stage
    import saes_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last
);

    logic [3:0] colA0, colB0, colA1, colB1;
    logic [3:0] mulA0, mulB0, mulA1, mulB1;
    logic [15:0] shifted, mixed, result;

    bufState_e  state_q, state_d;
    logic [15:0] outData_q, outData_d;
    logic        outLast_q, outLast_d;
    logic [15:0] skidData_q, skidData_d;
    logic        skidLast_q, skidLast_d;
    logic        readyEn_q;
    logic        accept, drain;

    // ShiftRows swaps the two bottom-row nibbles; top row stays put.
    assign colA0 = in_data[S00_LSB +: 4];
    assign colB0 = in_data[S11_LSB +: 4];
    assign colA1 = in_data[S01_LSB +: 4];
    assign colB1 = in_data[S10_LSB +: 4];
    assign shifted = {colA0, colB0, colA1, colB1};

    gf16_mul4 uMulA0 (.x_i(colA0), .y_o(mulA0));
    gf16_mul4 uMulB0 (.x_i(colB0), .y_o(mulB0));
    gf16_mul4 uMulA1 (.x_i(colA1), .y_o(mulA1));
    gf16_mul4 uMulB1 (.x_i(colB1), .y_o(mulB1));

    assign mixed  = {colA0 ^ mulB0, mulA0 ^ colB0, colA1 ^ mulB1, mulA1 ^ colB1};
    assign result = in_last ? shifted : mixed;

    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = outData_q;
    assign out_last  = outLast_q;

    // Skid mode only looks at registered state; single-register mode may
    // pass a beat through when the current output is being drained.
    assign in_ready = SKID_EN ? (readyEn_q && (state_q != BUF_FULL))
                              : (readyEn_q && ((state_q == BUF_EMPTY) || out_ready));

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Holds off acceptance until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) readyEn_q <= 1'b0;
        else     readyEn_q <= 1'b1;
    end

    // Buffer state and data registers; reset empties everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            outData_q  <= 16'h0000;
            outLast_q  <= 1'b0;
            skidData_q <= 16'h0000;
            skidLast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            skidData_q <= skidData_d;
            skidLast_q <= skidLast_d;
        end
    end

    // Next-state: new beats go to the output register when it is free or
    // draining, otherwise to the skid; a drain from FULL promotes the skid.
    always_comb begin
        state_d    = state_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        skidData_d = skidData_q;
        skidLast_d = skidLast_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    outData_d = result;
                    outLast_d = in_last;
                    state_d   = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (drain && accept) begin
                    outData_d = result;
                    outLast_d = in_last;
                end else if (drain) begin
                    state_d = BUF_EMPTY;
                end else if (accept) begin
                    skidData_d = result;
                    skidLast_d = in_last;
                    state_d    = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    outData_d = skidData_q;
                    outLast_d = skidLast_q;
                    state_d   = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_shift_mix_stage.sv
// Self-checking bench for shift_mix_stage (skid buffer enabled).
module tb_shift_mix_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int errors;
    int checks;
    int acceptedCnt;
    int consumedCnt;
    logic [16:0] q[$];
    logic        prevStall;
    logic [17:0] prevOut;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] expect_;
    } vec_t;

    vec_t vecs[7];

    shift_mix_stage #(.SKID_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Carry-less polynomial product followed by reduction by x^4+x+1.
    function automatic logic [3:0] refMul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'd0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int k = 6; k >= 4; k--)
            if (p[k]) p = p ^ (7'h13 << (k - 4));
        return p[3:0];
    endfunction

    // Expected {last, data} for one input beat.
    function automatic logic [16:0] mixRef(input logic [15:0] d, input logic last);
        logic [3:0] a0, b0, a1, b1;
        a0 = d[15:12];
        b0 = d[3:0];
        a1 = d[7:4];
        b1 = d[11:8];
        if (last) return {1'b1, a0, b0, a1, b1};
        return {1'b0, a0 ^ refMul(4'h4, b0), refMul(4'h4, a0) ^ b0,
                      a1 ^ refMul(4'h4, b1), refMul(4'h4, a1) ^ b1};
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    // Checks the outputs against the occupancy/order model, then advances one
    // clock and updates the model with what was accepted and consumed.
    task automatic stepCycle();
        logic acc, con;
        logic [16:0] pend;
        checkOutput("out_valid_occ", 32'(out_valid), 32'(q.size() > 0));
        checkOutput("in_ready_occ", 32'(in_ready), 32'(q.size() < 2));
        if (out_valid && q.size() > 0)
            checkOutput("out_beat", 32'({out_last, out_data}), 32'(q[0]));
        if (prevStall)
            checkOutput("stall_hold", 32'({out_valid, out_last, out_data}), 32'(prevOut));
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        prevStall = out_valid && !out_ready;
        prevOut   = {out_valid, out_last, out_data};
        pend = mixRef(in_data, in_last);
        @(posedge clk);
        #1;
        if (con && q.size() > 0) begin
            void'(q.pop_front());
            consumedCnt++;
        end
        if (acc) begin
            q.push_back(pend);
            acceptedCnt++;
        end
    endtask

    initial begin
        logic willAcc;
        logic r0;
        int   cyc;
        int   startCons;
        errors = 0;
        checks = 0;
        acceptedCnt = 0;
        consumedCnt = 0;
        prevStall = 1'b0;
        prevOut = '0;
        clk = 1'b0;
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        vecs[0] = '{16'h1234, 1'b0, 16'h20BE};
        vecs[1] = '{16'h1234, 1'b1, 16'h1432};
        vecs[2] = '{16'hFFFF, 1'b0, 16'h6666};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{16'hFFFF, 1'b1, 16'hFFFF};
        vecs[5] = '{16'h00F0, 1'b0, 16'h00F9};
        vecs[6] = '{16'h8000, 1'b1, 16'h8000};

        // Reset state, with a beat offered that must not be taken.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        // Known-answer vectors, one beat at a time.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].data, vecs[i].last, 1'b1);
            stepCycle();
            checkOutput("vector", 32'({out_valid, out_last, out_data}),
                        32'({1'b1, vecs[i].last, vecs[i].expect_}));
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
            stepCycle();
        end

        // Eight back-to-back beats, each visible one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i * 16'h1357 + 16'h0A0B), i[0], 1'b1);
            stepCycle();
            checkOutput("stream_lat1", 32'({out_valid, out_last, out_data}),
                        32'({1'b1, mixRef(16'(i * 16'h1357 + 16'h0A0B), i[0])}));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        stepCycle();

        // Stall with three beats offered: two fit, then in_ready drops.
        startCons = consumedCnt;
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        stepCycle();
        checkOutput("stall_in_ready_low", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 16'h5A5A, 1'b0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("stall_out_data", 32'(out_data), 32'h20BE);
        out_ready = 1'b1;
        cyc = 0;
        while ((in_valid || q.size() > 0) && cyc < 12) begin
            willAcc = in_valid && in_ready;
            stepCycle();
            if (willAcc) in_valid = 1'b0;
            cyc++;
        end
        checkOutput("stall_drained_cnt", 32'(consumedCnt - startCons), 32'd3);

        // Fill to FULL, then reset asynchronously mid-cycle.
        applyStimulus(1'b1, 16'h0F0F, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'hF0F0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_out_data", 32'(out_data), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_no_accept", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        q.delete();
        prevStall = 1'b0;
        #1;
        checkOutput("rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rel_no_stale", 32'(out_valid), 32'd0);

        // Random soak against the queue model, with occasional probes that
        // toggle out_ready mid-cycle and expect in_ready not to move.
        acceptedCnt = 0;
        cyc = 0;
        while (acceptedCnt < 10000 && cyc < 60000) begin
            applyStimulus($urandom_range(0, 99) < 70, 16'($urandom), 1'($urandom),
                          $urandom_range(0, 99) < 65);
            if (cyc % 7 == 0) begin
                r0 = in_ready;
                out_ready = ~out_ready;
                #1;
                checkOutput("in_ready_comb", 32'(in_ready), 32'(r0));
                out_ready = ~out_ready;
            end
            stepCycle();
            cyc++;
        end
        checkOutput("soak_accepted", 32'(acceptedCnt >= 10000), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            stepCycle();
            cyc++;
        end
        checkOutput("soak_drained", 32'(q.size()), 32'd0);
        checkOutput("soak_idle_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
